// File: rtl/serialize_word_to_bit_stream.sv
// Parallel-to-serial front end: W-bit words in over valid/ready, MSB-first bit stream out.
// Optional trailing even-parity bit per frame when SERIALIZE_PARITY_EN is defined.
module serialize_word_to_bit_stream #(
    parameter int unsigned W        = 8,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    output logic         up_ready,
    output logic         new_bit,
    output logic         bit_valid,
    output logic         last_bit
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

`ifdef SERIALIZE_PARITY_EN
    localparam int unsigned FRAME = W + 1;
`else
    localparam int unsigned FRAME = W;
`endif
    localparam int unsigned   CW       = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

    logic [0:0]    state_q, state_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          new_bit_d, bit_valid_d, last_bit_d;
    logic          at_last, accept;
`ifdef SERIALIZE_PARITY_EN
    logic          par_q, par_d;
`endif

    // Ready depends on state only so upstream may wait on it without a loop.
    assign at_last  = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    assign up_ready = (state_q == ST_IDLE) || at_last;
    assign accept   = up_valid && up_ready;

    // Next state plus next values of the registered serial outputs.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
`ifdef SERIALIZE_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            state_d = ST_SHIFT;
            sr_d    = up_data;
            cnt_d   = '0;
`ifdef SERIALIZE_PARITY_EN
            par_d   = ^up_data;
`endif
        end else if (state_q == ST_SHIFT) begin
            if (at_last) begin
                state_d = ST_IDLE;
                sr_d    = '0;
                cnt_d   = '0;
            end else begin
                sr_d  = {sr_q[W-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
            end
        end

        bit_valid_d = (state_d == ST_SHIFT);
        last_bit_d  = bit_valid_d && (cnt_d == LAST_CNT);
        new_bit_d   = IDLE_BIT;
        if (bit_valid_d) begin
            new_bit_d = sr_d[W-1];
`ifdef SERIALIZE_PARITY_EN
            if (cnt_d == LAST_CNT) begin
                new_bit_d = par_d;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            new_bit   <= IDLE_BIT;
            bit_valid <= 1'b0;
            last_bit  <= 1'b0;
`ifdef SERIALIZE_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            new_bit   <= new_bit_d;
            bit_valid <= bit_valid_d;
            last_bit  <= last_bit_d;
`ifdef SERIALIZE_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule
